// File: rtl/argmax_peak2.sv
// Frame-based I/Q peak finder: reports the largest and second-largest |x|^2
// of each frame, with the position of the peak and a threshold detect flag.
module argmax_peak2 #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int out_max_bits  = 16,
  parameter int out_shift     = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_axis_tvalid,
  input  logic [i_bits-1:0]       xi,
  input  logic [q_bits-1:0]       xq,
  output logic                    s_axis_tready,
  input  logic [out_max_bits-1:0] threshold,
  input  logic                    m_axis_tready,
  output logic                    s_axis_tvalid,
  output logic [out_max_bits-1:0] out_max,
  output logic [out_max_bits-1:0] out_second,
  output logic [index_bits-1:0]   index,
  output logic                    detect
);

  localparam int MB = 2 * i_bits;
  localparam logic [index_bits-1:0] LAST_POS =
    index_bits'(buffer_length - 1);
  localparam logic [MB-1:0] SAT_LIM = MB'({out_max_bits{1'b1}});

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [index_bits-1:0]   pos_q, pos_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic                    tready_q, tready_d;
  logic                    tvalid_q, tvalid_d;
  logic [out_max_bits-1:0] thr_q, thr_d;
  logic [out_max_bits-1:0] omax_q, omax_d;
  logic [out_max_bits-1:0] osec_q, osec_d;
  logic [index_bits-1:0]   oidx_q, oidx_d;
  logic                    det_q, det_d;

  logic                    v1_q, v1_d, first1_q, first1_d;
  logic [index_bits-1:0]   pos1_q, pos1_d;
  logic [MB-1:0]           sqi_q, sqi_d, sqq_q, sqq_d;
  logic                    v2_q, v2_d, first2_q, first2_d;
  logic [index_bits-1:0]   pos2_q, pos2_d;
  logic [MB-1:0]           sum_q, sum_d;
  logic [MB-1:0]           max_q, max_d, sec_q, sec_d;
  logic [index_bits-1:0]   idx_q, idx_d;

  logic                    accept, clear;
  logic signed [MB-1:0]    xi_e, xq_e;
  logic [out_max_bits-1:0] smax;

  function automatic logic [out_max_bits-1:0] scale(
    input logic [MB-1:0] m
  );
    logic [MB-1:0] s;
    s = m >> out_shift;
    if (s > SAT_LIM) scale = '1;
    else             scale = s[out_max_bits-1:0];
  endfunction

  assign accept = m_axis_tvalid && tready_q;
  assign xi_e   = {{(MB-i_bits){xi[i_bits-1]}}, xi};
  assign xq_e   = {{(MB-q_bits){xq[q_bits-1]}}, xq};
  assign smax   = scale(max_q);

  always_comb begin
    v1_d     = accept;
    first1_d = (pos_q == '0);
    pos1_d   = pos_q;
    sqi_d    = $unsigned(xi_e * xi_e);
    sqq_d    = $unsigned(xq_e * xq_e);
    v2_d     = v1_q;
    first2_d = first1_q;
    pos2_d   = pos1_q;
    sum_d    = sqi_q + sqq_q;
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dcnt_d   = dcnt_q;
    tready_d = tready_q;
    tvalid_d = tvalid_q;
    thr_d    = thr_q;
    omax_d   = omax_q;
    osec_d   = osec_q;
    oidx_d   = oidx_q;
    det_d    = det_q;
    clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d  = COLLECT;
        tready_d = 1'b1;
        pos_d    = '0;
      end
      COLLECT: begin
        if (accept) begin
          if (pos_q == LAST_POS) begin
            pos_d    = '0;
            state_d  = DRAIN;
            tready_d = 1'b0;
            dcnt_d   = '0;
            thr_d    = threshold;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // last tracker update lands one edge before this load
        if (dcnt_q == 2'd2) begin
          state_d  = HOLD;
          tvalid_d = 1'b1;
          omax_d   = smax;
          osec_d   = scale(sec_q);
          oidx_d   = idx_q;
          det_d    = (smax >= thr_q);
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (m_axis_tready) begin
          state_d  = COLLECT;
          tvalid_d = 1'b0;
          tready_d = 1'b1;
          clear    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    max_d = max_q;
    sec_d = sec_q;
    idx_d = idx_q;
    if (clear) begin
      max_d = '0;
      sec_d = '0;
      idx_d = '0;
    end else if (v2_q) begin
      if (first2_q) begin
        max_d = sum_q;
        sec_d = '0;
        idx_d = pos2_q;
      end else if (sum_q > max_q) begin
        sec_d = max_q;
        max_d = sum_q;
        idx_d = pos2_q;
      end else if (sum_q > sec_q) begin
        sec_d = sum_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      dcnt_q   <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      thr_q    <= '0;
      omax_q   <= '0;
      osec_q   <= '0;
      oidx_q   <= '0;
      det_q    <= 1'b0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      pos1_q   <= '0;
      sqi_q    <= '0;
      sqq_q    <= '0;
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      pos2_q   <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      sec_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dcnt_q   <= dcnt_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      thr_q    <= thr_d;
      omax_q   <= omax_d;
      osec_q   <= osec_d;
      oidx_q   <= oidx_d;
      det_q    <= det_d;
      v1_q     <= v1_d;
      first1_q <= first1_d;
      pos1_q   <= pos1_d;
      sqi_q    <= sqi_d;
      sqq_q    <= sqq_d;
      v2_q     <= v2_d;
      first2_q <= first2_d;
      pos2_q   <= pos2_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      sec_q    <= sec_d;
      idx_q    <= idx_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign s_axis_tvalid = tvalid_q;
  assign out_max       = omax_q;
  assign out_second    = osec_q;
  assign index         = oidx_q;
  assign detect        = det_q;

endmodule
